// File: rtl/axi4_stream_dnc_if.sv
// AXI4-Stream bundle with a parameterised lane count; d = consuming side, s = producing side.
// master/slave are aliases of s/d for bench-side readability.
interface axi4_stream_if #(
  parameter int DW = 16,
  parameter int N  = 1
) ();
  logic [N-1:0][DW-1:0] TDATA;
  logic [N-1:0]         TKEEP;
  logic                 TLAST;
  logic                 TVALID;
  logic                 TREADY;

  modport d      (input  TDATA, TKEEP, TLAST, TVALID, output TREADY);
  modport s      (output TDATA, TKEEP, TLAST, TVALID, input  TREADY);
  modport slave  (input  TDATA, TKEEP, TLAST, TVALID, output TREADY);
  modport master (output TDATA, TKEEP, TLAST, TVALID, input  TREADY);
endinterface

// File: rtl/axi4_stream_dnc.sv
// AXI4-Stream lane-count converter: packs narrow beats into wide words (DNO >= DNI)
// or splits wide words into narrow slices (DNI > DNO). All sto outputs are registered.
module axi4_stream_dnc #(
  parameter int DW  = 16,
  parameter int DNI = 1,
  parameter int DNO = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       clr,
  axi4_stream_if.d   sti,
  axi4_stream_if.s   sto
);

  localparam int NMAX = (DNI > DNO) ? DNI : DNO;
  localparam int NMIN = (DNI > DNO) ? DNO : DNI;
  localparam int R    = NMAX / NMIN;
  localparam int CW   = (R > 1) ? $clog2(R) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(R - 1);

  if ((NMAX % NMIN) != 0) begin : g_bad_ratio
    $error("axi4_stream_dnc: lane counts DNI=%0d DNO=%0d are not integer multiples", DNI, DNO);
  end

  logic [CW-1:0] r_cnt;
  logic          w_ctl_ok;

  assign w_ctl_ok = ~rst & ~clr & ena;

  if (DNO >= DNI) begin : g_pack
    logic [DNO-1:0][DW-1:0] r_data;
    logic [DNO-1:0]         r_keep;
    logic                   r_last;
    logic                   r_vld;
    logic                   w_rdy;
    logic                   w_acc;
    logic                   w_close;

    assign w_rdy   = w_ctl_ok & (~r_vld | sto.TREADY);
    assign w_acc   = sti.TVALID & w_rdy;
    assign w_close = (r_cnt == CNT_LAST) | sti.TLAST;

    // Output register doubles as the accumulation buffer; a beat at cnt 0 wipes the other lanes.
    always_ff @(posedge clk) begin
      if (rst || clr) begin
        r_data <= '0;
        r_keep <= '0;
        r_last <= 1'b0;
        r_vld  <= 1'b0;
        r_cnt  <= '0;
      end else begin
        if (r_vld && sto.TREADY) r_vld <= 1'b0;
        if (w_acc) begin
          for (int i = 0; i < DNO; i++) begin
            if (CW'(i / DNI) == r_cnt) begin
              r_data[i] <= sti.TDATA[i % DNI];
              r_keep[i] <= sti.TKEEP[i % DNI];
            end else if (r_cnt == '0) begin
              r_data[i] <= '0;
              r_keep[i] <= 1'b0;
            end
          end
          if (w_close) begin
            r_vld  <= 1'b1;
            r_last <= sti.TLAST;
            r_cnt  <= '0;
          end else begin
            r_cnt  <= r_cnt + CW'(1);
          end
        end
      end
    end

    assign sti.TREADY = w_rdy;
    assign sto.TDATA  = r_data;
    assign sto.TKEEP  = r_keep;
    assign sto.TLAST  = r_last;
    assign sto.TVALID = r_vld;

  end else begin : g_split
    logic [DNI-1:0][DW-1:0] r_buf;
    logic [DNI-1:0]         r_bkeep;
    logic                   r_blast;
    logic                   r_full;
    logic                   w_last_slice;
    logic                   w_ohs;
    logic                   w_rdy;
    logic                   w_acc;
    logic [DNO-1:0][DW-1:0] w_data;
    logic [DNO-1:0]         w_keep;

    assign w_last_slice = (r_cnt == CNT_LAST);
    assign w_ohs        = r_full & sto.TREADY;
    assign w_rdy        = w_ctl_ok & (~r_full | (sto.TREADY & w_last_slice));
    assign w_acc        = sti.TVALID & w_rdy;

    // Slice select is a mux over registered lanes only, so no sti payload reaches sto.
    always_comb begin
      w_data = '0;
      w_keep = '0;
      for (int k = 0; k < R; k++) begin
        if (r_cnt == CW'(k)) begin
          for (int j = 0; j < DNO; j++) begin
            w_data[j] = r_buf[k*DNO + j];
            w_keep[j] = r_bkeep[k*DNO + j];
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst || clr) begin
        r_buf   <= '0;
        r_bkeep <= '0;
        r_blast <= 1'b0;
        r_full  <= 1'b0;
        r_cnt   <= '0;
      end else begin
        if (w_ohs) begin
          r_cnt <= w_last_slice ? '0 : r_cnt + CW'(1);
          if (w_last_slice) r_full <= 1'b0;
        end
        if (w_acc) begin
          r_buf   <= sti.TDATA;
          r_bkeep <= sti.TKEEP;
          r_blast <= sti.TLAST;
          r_full  <= 1'b1;
        end
      end
    end

    assign sti.TREADY = w_rdy;
    assign sto.TDATA  = w_data;
    assign sto.TKEEP  = w_keep;
    assign sto.TLAST  = r_blast & w_last_slice;
    assign sto.TVALID = r_full;
  end

endmodule

// File: tb/tb_axi4_stream_dnc.sv
// Bench for axi4_stream_dnc: pack 1->2, 1->4 and split 4->1, 2->1 instances driven by
// a vector table, directed corner sequences and random traffic against a word-level model.
module tb_axi4_stream_dnc;

  logic clk = 1'b0;
  logic rst, ena, clr;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  axi4_stream_if #(.DW(16), .N(1)) p2i ();
  axi4_stream_if #(.DW(16), .N(2)) p2o ();
  axi4_stream_if #(.DW(16), .N(1)) p4i ();
  axi4_stream_if #(.DW(16), .N(4)) p4o ();
  axi4_stream_if #(.DW(16), .N(4)) s4i ();
  axi4_stream_if #(.DW(16), .N(1)) s4o ();
  axi4_stream_if #(.DW(16), .N(2)) s2i ();
  axi4_stream_if #(.DW(16), .N(1)) s2o ();

  axi4_stream_dnc #(.DW(16), .DNI(1), .DNO(2)) u_p2 (.clk(clk), .rst(rst), .ena(ena), .clr(clr), .sti(p2i), .sto(p2o));
  axi4_stream_dnc #(.DW(16), .DNI(1), .DNO(4)) u_p4 (.clk(clk), .rst(rst), .ena(ena), .clr(clr), .sti(p4i), .sto(p4o));
  axi4_stream_dnc #(.DW(16), .DNI(4), .DNO(1)) u_s4 (.clk(clk), .rst(rst), .ena(ena), .clr(clr), .sti(s4i), .sto(s4o));
  axi4_stream_dnc #(.DW(16), .DNI(2), .DNO(1)) u_s2 (.clk(clk), .rst(rst), .ena(ena), .clr(clr), .sti(s2i), .sto(s2o));

  typedef struct {
    logic [15:0] d;
    logic        l;
    logic        ev;
    logic [31:0] ed;
    logic [1:0]  ek;
    logic        el;
  } vec_t;

  typedef struct {
    logic [63:0] d;
    logic [3:0]  k;
    logic        l;
  } ow_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic do_rst;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic p2_send(input logic [15:0] d);
    p2i.TVALID = 1'b1; p2i.TDATA = d; p2i.TKEEP = 1'b1; p2i.TLAST = 1'b0;
    tick();
    p2i.TVALID = 1'b0;
  endtask

  vec_t        tbl [7];
  ow_t         pq [$];
  ow_t         sq [$];
  ow_t         cur, held;
  logic [15:0] pin_d [60];
  logic        pin_k [60];
  logic        pin_l [60];
  logic [63:0] sin_d [30];
  logic [3:0]  sin_k [30];
  logic        sin_l [30];
  logic        hold;
  int          n, idx, oi, cyc, k;

  initial begin
    tbl[0] = '{16'h1111, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0};
    tbl[1] = '{16'h2222, 1'b0, 1'b1, 32'h2222_1111, 2'b11, 1'b0};
    tbl[2] = '{16'h3333, 1'b1, 1'b1, 32'h0000_3333, 2'b01, 1'b1};
    tbl[3] = '{16'h4444, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0};
    tbl[4] = '{16'h5555, 1'b1, 1'b1, 32'h5555_4444, 2'b11, 1'b1};
    tbl[5] = '{16'h6666, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0};
    tbl[6] = '{16'h7777, 1'b0, 1'b1, 32'h7777_6666, 2'b11, 1'b0};

    rst = 1'b1; ena = 1'b1; clr = 1'b0;
    p2i.TVALID = 0; p2i.TDATA = '0; p2i.TKEEP = '0; p2i.TLAST = 0; p2o.TREADY = 1;
    p4i.TVALID = 0; p4i.TDATA = '0; p4i.TKEEP = '0; p4i.TLAST = 0; p4o.TREADY = 1;
    s4i.TVALID = 0; s4i.TDATA = '0; s4i.TKEEP = '0; s4i.TLAST = 0; s4o.TREADY = 1;
    s2i.TVALID = 0; s2i.TDATA = '0; s2i.TKEEP = '0; s2i.TLAST = 0; s2o.TREADY = 1;

    // Reset state
    tick(); tick();
    chk("rst p2 vld",  64'(p2o.TVALID), 64'h0);
    chk("rst p2 data", 64'(p2o.TDATA),  64'h0);
    chk("rst p2 keep", 64'(p2o.TKEEP),  64'h0);
    chk("rst p2 last", 64'(p2o.TLAST),  64'h0);
    chk("rst p2 rdy",  64'(p2i.TREADY), 64'h0);
    chk("rst s4 vld",  64'(s4o.TVALID), 64'h0);
    chk("rst s4 data", 64'(s4o.TDATA),  64'h0);
    chk("rst s4 rdy",  64'(s4i.TREADY), 64'h0);
    rst = 1'b0;

    // Vector table on the 1->2 packer, output always ready
    for (int i = 0; i < 7; i++) begin
      p2i.TVALID = 1'b1; p2i.TDATA = tbl[i].d; p2i.TKEEP = 1'b1; p2i.TLAST = tbl[i].l;
      settle();
      chk("tbl rdy", 64'(p2i.TREADY), 64'h1);
      tick();
      chk("tbl vld", 64'(p2o.TVALID), 64'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk("tbl data", 64'(p2o.TDATA), 64'(tbl[i].ed));
        chk("tbl keep", 64'(p2o.TKEEP), 64'(tbl[i].ek));
        chk("tbl last", 64'(p2o.TLAST), 64'(tbl[i].el));
      end
    end
    p2i.TVALID = 1'b0;
    tick();
    chk("tbl drain vld", 64'(p2o.TVALID), 64'h0);

    // Enable hold keeps a partial word
    p2_send(16'hAAAA);
    p2i.TVALID = 1'b1; p2i.TDATA = 16'hBBBB; ena = 1'b0;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("hold rdy", 64'(p2i.TREADY), 64'h0);
      tick();
      chk("hold vld", 64'(p2o.TVALID), 64'h0);
    end
    ena = 1'b1;
    settle();
    chk("hold resume rdy", 64'(p2i.TREADY), 64'h1);
    tick();
    p2i.TVALID = 1'b0;
    chk("hold vld out", 64'(p2o.TVALID), 64'h1);
    chk("hold data",    64'(p2o.TDATA),  64'hBBBB_AAAA);
    chk("hold keep",    64'(p2o.TKEEP),  64'h3);
    tick();

    // Clear mid-word
    p2_send(16'hCCCC);
    clr = 1'b1;
    p2i.TVALID = 1'b1; p2i.TDATA = 16'hEEEE;
    settle();
    chk("clr rdy", 64'(p2i.TREADY), 64'h0);
    tick();
    clr = 1'b0; p2i.TVALID = 1'b0;
    chk("clr vld", 64'(p2o.TVALID), 64'h0);
    p2_send(16'h1234);
    chk("clr vld1", 64'(p2o.TVALID), 64'h0);
    p2_send(16'h5678);
    chk("clr vld2", 64'(p2o.TVALID), 64'h1);
    chk("clr data", 64'(p2o.TDATA),  64'h5678_1234);
    chk("clr keep", 64'(p2o.TKEEP),  64'h3);
    tick();

    // Reset mid-word
    p2_send(16'hCCCC);
    rst = 1'b1;
    settle();
    chk("midrst rdy", 64'(p2i.TREADY), 64'h0);
    tick();
    rst = 1'b0;
    chk("midrst vld", 64'(p2o.TVALID), 64'h0);
    p2_send(16'h9ABC);
    chk("midrst vld1", 64'(p2o.TVALID), 64'h0);
    p2_send(16'hDEF0);
    chk("midrst vld2", 64'(p2o.TVALID), 64'h1);
    chk("midrst data", 64'(p2o.TDATA),  64'hDEF0_9ABC);
    chk("midrst keep", 64'(p2o.TKEEP),  64'h3);
    tick();

    // 1->4 partial word closed by TLAST, then a full word from cnt 0
    p4i.TVALID = 1'b1; p4i.TKEEP = 1'b1;
    for (int b = 0; b < 3; b++) begin
      p4i.TDATA = 16'hA0A0 + 16'(b) * 16'h1010;
      p4i.TLAST = (b == 2);
      tick();
      chk("p4 part vld", 64'(p4o.TVALID), 64'(b == 2));
    end
    p4i.TVALID = 1'b0;
    chk("p4 part data", 64'(p4o.TDATA), 64'h0000_C0C0_B0B0_A0A0);
    chk("p4 part keep", 64'(p4o.TKEEP), 64'h7);
    chk("p4 part last", 64'(p4o.TLAST), 64'h1);
    tick();
    chk("p4 part drain", 64'(p4o.TVALID), 64'h0);
    p4i.TVALID = 1'b1; p4i.TLAST = 1'b0;
    for (int b = 0; b < 4; b++) begin
      p4i.TDATA = 16'(b + 1);
      tick();
      chk("p4 full vld", 64'(p4o.TVALID), 64'(b == 3));
    end
    p4i.TVALID = 1'b0;
    chk("p4 full data", 64'(p4o.TDATA), 64'h0004_0003_0002_0001);
    chk("p4 full keep", 64'(p4o.TKEEP), 64'hF);
    chk("p4 full last", 64'(p4o.TLAST), 64'h0);
    tick();

    // 4->1 split with toggling output ready
    s4i.TVALID = 1'b1; s4i.TDATA = 64'hDDDD_CCCC_BBBB_AAAA; s4i.TKEEP = 4'hF; s4i.TLAST = 1'b1;
    s4o.TREADY = 1'b0;
    settle();
    chk("s4 load rdy", 64'(s4i.TREADY), 64'h1);
    tick();
    s4i.TVALID = 1'b0;
    k = 0;
    for (int c = 0; c < 12 && k < 4; c++) begin
      s4o.TREADY = (c % 2 == 0);
      settle();
      chk("s4 vld", 64'(s4o.TVALID), 64'h1);
      chk("s4 in rdy", 64'(s4i.TREADY), 64'(s4o.TREADY && k == 3));
      if (s4o.TVALID && s4o.TREADY) begin
        chk("s4 data", 64'(s4o.TDATA), 64'(16'hAAAA + 16'(k) * 16'h1111));
        chk("s4 last", 64'(s4o.TLAST), 64'(k == 3));
        k++;
      end
      tick();
    end
    chk("s4 count", 64'(k), 64'd4);
    chk("s4 empty", 64'(s4o.TVALID), 64'h0);
    s4o.TREADY = 1'b1;

    // 2->1 split streaming without bubbles
    n = 0;
    s2i.TVALID = 1'b1; s2i.TKEEP = 2'b11; s2i.TLAST = 1'b0;
    for (int c = 0; c < 12; c++) begin
      s2i.TDATA = {16'(2*n + 1), 16'(2*n)};
      settle();
      chk("s2 in rdy", 64'(s2i.TREADY), 64'(c % 2 == 0));
      if (c >= 1) begin
        chk("s2 vld",  64'(s2o.TVALID), 64'h1);
        chk("s2 data", 64'(s2o.TDATA),  64'(c - 1));
      end
      if (s2i.TREADY) n++;
      tick();
    end
    s2i.TVALID = 1'b0;
    tick(); tick(); tick();

    // Random traffic on the 1->4 packer against a word-level model
    do_rst();
    for (int b = 0; b < 60; b++) begin
      pin_d[b] = 16'($urandom);
      pin_k[b] = ($urandom_range(0, 5) != 0);
      pin_l[b] = (b == 59) || ($urandom_range(0, 4) == 0);
    end
    cur = '{64'h0, 4'h0, 1'b0};
    n = 0;
    for (int b = 0; b < 60; b++) begin
      cur.d[n*16 +: 16] = pin_d[b];
      cur.k[n] = pin_k[b];
      n++;
      if (n == 4 || pin_l[b]) begin
        cur.l = pin_l[b];
        pq.push_back(cur);
        cur = '{64'h0, 4'h0, 1'b0};
        n = 0;
      end
    end
    idx = 0; oi = 0; cyc = 0; hold = 1'b0;
    while (oi < pq.size() && cyc < 3000) begin
      cyc++;
      ena = ($urandom_range(0, 7) != 0);
      p4i.TVALID = (idx < 60) && ($urandom_range(0, 3) != 0);
      if (idx < 60) begin
        p4i.TDATA = pin_d[idx]; p4i.TKEEP = pin_k[idx]; p4i.TLAST = pin_l[idx];
      end
      p4o.TREADY = ($urandom_range(0, 2) != 0);
      settle();
      if (hold) begin
        chk("p4 rnd stable vld",  64'(p4o.TVALID), 64'h1);
        chk("p4 rnd stable data", 64'(p4o.TDATA),  held.d);
      end
      if (!ena) chk("p4 rnd ena rdy", 64'(p4i.TREADY), 64'h0);
      if (p4o.TVALID && p4o.TREADY) begin
        chk("p4 rnd data", 64'(p4o.TDATA), pq[oi].d);
        chk("p4 rnd keep", 64'(p4o.TKEEP), 64'(pq[oi].k));
        chk("p4 rnd last", 64'(p4o.TLAST), 64'(pq[oi].l));
        oi++;
      end
      hold = p4o.TVALID && !p4o.TREADY;
      held.d = 64'(p4o.TDATA);
      if (p4i.TVALID && p4i.TREADY) idx++;
      tick();
    end
    chk("p4 rnd words", 64'(oi), 64'(pq.size()));
    p4i.TVALID = 1'b0; p4o.TREADY = 1'b1; ena = 1'b1;

    // Random traffic on the 4->1 splitter against a slice-level model
    do_rst();
    for (int w = 0; w < 30; w++) begin
      sin_d[w] = {$urandom, $urandom};
      sin_k[w] = 4'($urandom);
      sin_l[w] = ($urandom_range(0, 2) == 0);
      for (int s = 0; s < 4; s++)
        sq.push_back('{64'(sin_d[w][s*16 +: 16]), 4'(sin_k[w][s]), sin_l[w] && (s == 3)});
    end
    idx = 0; oi = 0; cyc = 0; hold = 1'b0;
    while (oi < sq.size() && cyc < 3000) begin
      cyc++;
      ena = ($urandom_range(0, 7) != 0);
      s4i.TVALID = (idx < 30) && ($urandom_range(0, 3) != 0);
      if (idx < 30) begin
        s4i.TDATA = sin_d[idx]; s4i.TKEEP = sin_k[idx]; s4i.TLAST = sin_l[idx];
      end
      s4o.TREADY = ($urandom_range(0, 3) != 0);
      settle();
      if (hold) begin
        chk("s4 rnd stable vld",  64'(s4o.TVALID), 64'h1);
        chk("s4 rnd stable data", 64'(s4o.TDATA),  held.d);
      end
      if (!ena) chk("s4 rnd ena rdy", 64'(s4i.TREADY), 64'h0);
      if (s4o.TVALID && s4o.TREADY) begin
        chk("s4 rnd data", 64'(s4o.TDATA), sq[oi].d);
        chk("s4 rnd keep", 64'(s4o.TKEEP), 64'(sq[oi].k));
        chk("s4 rnd last", 64'(s4o.TLAST), 64'(sq[oi].l));
        oi++;
      end
      hold = s4o.TVALID && !s4o.TREADY;
      held.d = 64'(s4o.TDATA);
      if (s4i.TVALID && s4i.TREADY) idx++;
      tick();
    end
    chk("s4 rnd slices", 64'(oi), 64'(sq.size()));
    s4i.TVALID = 1'b0; s4o.TREADY = 1'b1; ena = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4_stream_dnc.md
AXI4_STREAM_DNC -- requirements
Module: axi4_stream_dnc

Interface
REQ-001 Parameter DW, default 16: width in bits of one data element (lane).
REQ-002 Parameter DNI, default 1: number of data elements per input beat.
REQ-003 Parameter DNO, default 2: number of data elements per output beat.
REQ-004 Port clk  input  1: single clock for all logic.
REQ-005 Port rst  input  1: reset, synchronous, active-high.
REQ-006 Port ena  input  1: enable; low blocks input acceptance only.
REQ-007 Port clr  input  1: synchronous clear; discards buffered content.
REQ-008 Port sti  axi4_stream_if.d  DNI lanes: input stream; carries TDATA [DNI-1:0][DW-1:0], TKEEP [DNI-1:0], TLAST, TVALID and TREADY.
REQ-009 Port sto  axi4_stream_if.s  DNO lanes: output stream; carries TDATA [DNO-1:0][DW-1:0], TKEEP [DNO-1:0], TLAST, TVALID and TREADY.

Function
REQ-010 Elaboration SHALL fail with $error unless max(DNI,DNO) % min(DNI,DNO) == 0.
REQ-011 Define R = max(DNI,DNO)/min(DNI,DNO); define counter cnt of width max(1,$clog2(R)), range 0..R-1.
REQ-012 All outputs SHALL be registered; no combinational path from sti.TDATA/TKEEP/TLAST to sto.
REQ-013 An input handshake SHALL occur only when sti.TVALID & sti.TREADY are both high; likewise, an output handshake requires sto.TVALID & sto.TREADY.
REQ-014 sto.TVALID SHALL NOT depend on sto.TREADY, and SHALL stay asserted with stable payload until the output handshake.
REQ-015 Pack mode (DNO >= DNI; the equal case is a register slice with R=1): sti.TREADY = ena & (~sto.TVALID | sto.TREADY).
REQ-016 Pack: an accepted input beat SHALL be written to output lanes [cnt*DNI +: DNI] for both TDATA and TKEEP.
REQ-017 Pack: when the first beat of a new output word is written, all other lanes SHALL have TKEEP cleared to 0 and TDATA cleared to 0.
REQ-018 Pack: if the accepted beat has cnt==R-1 or TLAST==1, the design SHALL, on the next cycle, set sto.TVALID=1 with sto.TLAST = sti.TLAST, and SHALL reset cnt to 0; otherwise it SHALL increment cnt.
REQ-019 Pack: a partial word closed by TLAST SHALL carry TKEEP=0 and TDATA=0 in all unfilled lanes.
REQ-020 Pack: an output handshake and an input accept in the same cycle SHALL both complete; the new beat starts the next word.
REQ-021 Split mode (DNI > DNO): the input word, its TKEEP and its TLAST SHALL be held in a buffer with a full flag; sto.TVALID = full.
REQ-022 Split: sto.TDATA/TKEEP SHALL equal buffer lanes [cnt*DNO +: DNO].
REQ-023 Split: sto.TLAST = buffered TLAST & (cnt==R-1).
REQ-024 Split: sti.TREADY = ena & (~full | (sto.TREADY & cnt==R-1)).
REQ-025 Split: on each output handshake, cnt SHALL increment, wrapping to 0 after R-1.
REQ-026 Split: full SHALL clear after the last slice unless a new input is accepted in the same cycle.
REQ-027 Split: every slice SHALL be emitted regardless of TKEEP, giving exactly R output beats per input beat.
REQ-028 Throughput: pack SHALL sustain 1 input beat per cycle; split SHALL sustain 1 output beat per cycle while sto.TREADY is high.
REQ-029 ena low SHALL force sti.TREADY=0 while output drains normally; a partial pack word is held, not flushed.
REQ-030 clr high SHALL, next cycle, set sto.TVALID=0, full=0 and cnt=0, and SHALL discard any partial word.
REQ-031 clr high SHALL force sti.TREADY=0 in the same cycle.
REQ-032 Latency: the first output valid SHALL appear 1 cycle after the completing input handshake.

Reset
REQ-033 While rst is high, sto.TVALID, sto.TLAST, sto.TKEEP, sto.TDATA, cnt and full SHALL all be 0, and sti.TREADY SHALL be 0.
REQ-034 rst SHALL have priority over clr and ena, and SHALL abort any word in progress mid-operation with no output produced from it.

Verification
REQ-035 Pack DW=16 DNI=1 DNO=2, inputs 0x1111,0x2222 back-to-back, sto.TREADY=1 -> one beat: TDATA={0x2222,0x1111}, TKEEP=2'b11, TVALID 1 cycle after the 2nd accept.
REQ-036 Pack DNI=1 DNO=4, three beats A,B,C with TLAST on C -> TDATA={0,C,B,A}, TKEEP=4'b0111, TLAST=1, cnt=0 afterwards.
REQ-037 Split DNI=4 DNO=1, word {D,C,B,A} with TLAST=1, TREADY toggling 1010... -> outputs A,B,C,D in order, TLAST only on D, sti.TREADY high only with D's handshake.
REQ-038 Split DNI=2 DNO=1, continuous input with TREADY=1 -> 1 output/cycle, no bubbles, sti.TREADY high every 2nd cycle.
REQ-039 Pack DNI=1 DNO=2, 1 beat accepted then ena=0 for 5 cycles then 1 beat -> no output during hold, then a full 2-lane word; sti.TREADY=0 throughout hold.
REQ-040 Mid-word clr, and separately rst, after 1 of 2 beats -> TVALID stays 0, the next two inputs form a clean word with TKEEP=2'b11.
